flash_read_arbiter: RTL and testbench



---
 rtl/flash_read_arbiter.sv | 103 ++++++++++
 tb/tb_flash_read_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: two-port AXI4-Lite read arbiter, one outstanding read, round-robin grant.
// Define FLASH_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
module flash_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [2:0]        s0_arprot,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [DATA_W-1:0] s0_rdata,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [2:0]        s1_arprot,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              grant
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state;
  logic   win;
`ifdef FLASH_ARB_FIXED_PRIO_EN
  assign win = !s0_arvalid;
`else
  logic ptr;
  assign win = (s0_arvalid && s1_arvalid) ? ptr : s1_arvalid;
`endif
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      s0_arready <= 1'b0;
      s1_arready <= 1'b0;
      s0_rvalid  <= 1'b0;
      s1_rvalid  <= 1'b0;
      s0_rdata   <= '0;
      s1_rdata   <= '0;
      m_arvalid  <= 1'b0;
      m_araddr   <= '0;
      m_arprot   <= '0;
      m_rready   <= 1'b0;
      busy       <= 1'b0;
      grant      <= 1'b0;
`ifndef FLASH_ARB_FIXED_PRIO_EN
      ptr        <= 1'b0;
`endif
    end else begin
      s0_arready <= 1'b0;
      s1_arready <= 1'b0;
      case (state)
        IDLE: if (s0_arvalid || s1_arvalid) begin
          grant      <= win;
          m_araddr   <= win ? s1_araddr : s0_araddr;
          m_arprot   <= win ? s1_arprot : s0_arprot;
          s0_arready <= !win;
          s1_arready <= win;
          m_arvalid  <= 1'b1;
          busy       <= 1'b1;
          state      <= ADDR;
        end
        ADDR: if (m_arready) begin
          m_arvalid <= 1'b0;
          m_rready  <= 1'b1;
          state     <= DATA;
        end
        DATA: if (m_rvalid) begin
          m_rready <= 1'b0;
          if (grant) begin
            s1_rdata  <= m_rdata;
            s1_rvalid <= 1'b1;
          end else begin
            s0_rdata  <= m_rdata;
            s0_rvalid <= 1'b1;
          end
          state <= RESP;
        end
        RESP: if (grant ? s1_rready : s0_rready) begin
          s0_rvalid <= 1'b0;
          s1_rvalid <= 1'b0;
          busy      <= 1'b0;
`ifndef FLASH_ARB_FIXED_PRIO_EN
          ptr       <= !grant;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: random requesters and flash responder against a transaction-level model.
module tb_flash_read_arbiter;
  logic        CLK = 1'b0, RST = 1'b1;
  logic [1:0]  arv = '0, rrdy = '0, drop = '0;
  logic [31:0] ara [2];
  logic [2:0]  arp [2];
  logic        m_arready = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        s0_arready, s1_arready, s0_rvalid, s1_rvalid;
  logic [31:0] s0_rdata, s1_rdata, m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arvalid, m_rready, busy, grant;
  int          n_vec = 0, n_err = 0, phase = 0;
  logic        mptr = 1'b0, cur = 1'b0, w, e_grant = 1'b0;
  logic [31:0] e_addr = '0;
  logic [2:0]  e_prot = '0;
  logic [31:0] e_rd [2];
  logic [1:0]  e_arr;

  always #5 CLK = ~CLK;

  flash_read_arbiter dut (
    .CLK(CLK), .RST(RST),
    .s0_arvalid(arv[0]), .s0_arready(s0_arready), .s0_araddr(ara[0]), .s0_arprot(arp[0]),
    .s0_rvalid(s0_rvalid), .s0_rready(rrdy[0]), .s0_rdata(s0_rdata),
    .s1_arvalid(arv[1]), .s1_arready(s1_arready), .s1_araddr(ara[1]), .s1_arprot(arp[1]),
    .s1_rvalid(s1_rvalid), .s1_rready(rrdy[1]), .s1_rdata(s1_rdata),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .busy(busy), .grant(grant)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_rst();
    chk("rst_ctl", {28'd0, s1_arready, s0_arready, m_arvalid, m_rready}, 32'd0);
    chk("rst_sts", {28'd0, s1_rvalid, s0_rvalid, busy, grant}, 32'd0);
    chk("rst_addr", m_araddr, 32'd0);
    chk("rst_prot", {29'd0, m_arprot}, 32'd0);
    chk("rst_rd0", s0_rdata, 32'd0);
    chk("rst_rd1", s1_rdata, 32'd0);
  endtask

  initial begin
    ara = '{32'd0, 32'd0};
    arp = '{3'd0, 3'd0};
    e_rd = '{32'd0, 32'd0};
    repeat (2) @(negedge CLK);
    chk_rst();
    RST = 1'b0;
    repeat (3000) begin
      @(negedge CLK);
      e_arr = 2'b00;
      case (phase)
        0: if (|arv) begin
`ifdef FLASH_ARB_FIXED_PRIO_EN
          w = !arv[0];
`else
          w = (&arv) ? mptr : arv[1];
`endif
          cur = w; e_grant = w; e_addr = ara[w]; e_prot = arp[w]; e_arr[w] = 1'b1; phase = 1;
        end
        1: if (m_arready) phase = 2;
        2: if (m_rvalid) begin e_rd[cur] = m_rdata; phase = 3; end
        3: if (rrdy[cur]) begin phase = 0; mptr = !cur; end
        default: phase = 0;
      endcase
      chk("arready", {30'd0, s1_arready, s0_arready}, {30'd0, e_arr});
      chk("m_arvalid", {31'd0, m_arvalid}, {31'd0, phase == 1});
      chk("m_rready", {31'd0, m_rready}, {31'd0, phase == 2});
      chk("rvalid", {30'd0, s1_rvalid, s0_rvalid}, phase == 3 ? (cur ? 32'd2 : 32'd1) : 32'd0);
      chk("busy", {31'd0, busy}, {31'd0, phase != 0});
      chk("grant", {31'd0, grant}, {31'd0, e_grant});
      chk("m_araddr", m_araddr, e_addr);
      chk("m_arprot", {29'd0, m_arprot}, {29'd0, e_prot});
      chk("s0_rdata", s0_rdata, e_rd[0]);
      chk("s1_rdata", s1_rdata, e_rd[1]);
      for (int i = 0; i < 2; i++) begin
        if (e_arr[i]) drop[i] = 1'b1;
        else if (drop[i]) begin arv[i] = 1'b0; drop[i] = 1'b0; end
        else if (!arv[i] && $urandom_range(0, 3) != 0) begin
          arv[i] = 1'b1; ara[i] = $urandom; arp[i] = 3'($urandom);
        end
      end
      rrdy = 2'($urandom);
      m_arready = $urandom_range(0, 2) == 0;
      m_rvalid = (phase == 2) && $urandom_range(0, 3) == 0;
      m_rdata = $urandom;
      if (phase == 2 && $urandom_range(0, 19) == 0) begin
        #1 RST = 1'b1;
        #1 chk_rst();
        arv = '0; drop = '0; rrdy = '0; m_arready = 1'b0; m_rvalid = 1'b0;
        phase = 0; mptr = 1'b0; e_grant = 1'b0; e_addr = '0; e_prot = '0; e_rd = '{32'd0, 32'd0};
        #1 RST = 1'b0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
